// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing a single ALU.
// Holds one registered result until the owning requester accepts it.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

module alu
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_q,
  output logic        o_zero,
  output logic        o_neg
);
  always_comb begin
    o_q = 32'd0;
    case (i_op)
      ALU_ADD:  o_q = i_a + i_b;
      ALU_SUB:  o_q = i_a - i_b;
      ALU_AND:  o_q = i_a & i_b;
      ALU_OR:   o_q = i_a | i_b;
      ALU_XOR:  o_q = i_a ^ i_b;
      ALU_SLL:  o_q = i_a << i_b[4:0];
      ALU_SRL:  o_q = i_a >> i_b[4:0];
      ALU_SRA:  o_q = $unsigned($signed(i_a) >>> i_b[4:0]);
      ALU_SLT:  o_q = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_q = {31'd0, i_a < i_b};
      default:  o_q = 32'd0;
    endcase
  end

  assign o_zero = (o_q == 32'd0);
  assign o_neg  = o_q[31];
endmodule

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  input  alu_op_e          req_op0,
  input  alu_op_e          req_op1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_q,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_prio;
  logic             r_owner;
  logic [31:0]      r_rsp_q;
  logic             r_rsp_zero;
  logic             r_rsp_neg;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [CNT_W-1:0] r_op_count;

  logic             w_rsp_hs;
  logic             w_can_grant;
  logic             w_gnt;
  logic             w_accept;
  logic [1:0]       w_req_ready;
  logic [31:0]      w_alu_a;
  logic [31:0]      w_alu_b;
  alu_op_e          w_alu_op;
  logic [31:0]      w_alu_q;
  logic             w_alu_zero;
  logic             w_alu_neg;

  assign w_alu_a  = w_gnt ? req_a1  : req_a0;
  assign w_alu_b  = w_gnt ? req_b1  : req_b0;
  assign w_alu_op = w_gnt ? req_op1 : req_op0;

  alu u_alu (
    .i_a    (w_alu_a),
    .i_b    (w_alu_b),
    .i_op   (w_alu_op),
    .o_q    (w_alu_q),
    .o_zero (w_alu_zero),
    .o_neg  (w_alu_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // rst_n gates acceptance so req_ready stays low throughout reset.
  always_comb begin
    w_state_next = r_state;
    w_rsp_hs     = (r_state == HOLD) && rsp_ready[r_owner];
    w_can_grant  = (r_state == IDLE) || w_rsp_hs;
    w_gnt        = (req_valid == 2'b11) ? r_prio : req_valid[1];
    w_accept     = w_can_grant && (|req_valid) && rst_n;
    w_req_ready  = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    case (r_state)
      IDLE: if (w_accept) w_state_next = HOLD;
      HOLD: begin
        if (w_accept)      w_state_next = HOLD;
        else if (w_rsp_hs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio     <= 1'b0;
      r_owner    <= 1'b0;
      r_rsp_q    <= 32'd0;
      r_rsp_zero <= 1'b0;
      r_rsp_neg  <= 1'b0;
      r_rsp_tag  <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_prio     <= ~w_gnt;
        r_owner    <= w_gnt;
        r_rsp_q    <= w_alu_q;
        r_rsp_zero <= w_alu_zero;
        r_rsp_neg  <= w_alu_neg;
        r_rsp_tag  <= w_gnt ? req_tag1 : req_tag0;
      end
      if (w_rsp_hs) r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == HOLD) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_q     = r_rsp_q;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_neg   = r_rsp_neg;
  assign rsp_tag   = r_rsp_tag;
  assign op_count  = r_op_count;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (CNT_W=4 so the counter wrap is reachable).
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [31:0]      req_a0, req_b0, req_a1, req_b1;
  alu_op_e          req_op0, req_op1;
  logic [TAG_W-1:0] req_tag0, req_tag1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_q;
  logic             rsp_zero, rsp_neg;
  logic [TAG_W-1:0] rsp_tag;
  logic [CNT_W-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
    .rsp_tag(rsp_tag), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    req_op0 = ALU_ADD; req_op1 = ALU_ADD; req_tag0 = 0; req_tag1 = 0;
    #12;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    n_tests++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    n_tests++; if ({rsp_q, rsp_zero, rsp_neg, rsp_tag} !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got q=%h z=%b n=%b t=%h expected 0", rsp_q, rsp_zero, rsp_neg, rsp_tag); end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = ALU_ADD; req_tag0 = 4'd3; rsp_ready = 2'b00;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); end
    n_tests++; if (rsp_q !== 32'd12) begin n_fail++; $display("FAIL single_rsp_q: got %h expected 0000000c", rsp_q); end
    n_tests++; if ({rsp_zero, rsp_neg} !== 2'b00) begin n_fail++; $display("FAIL single_flags: got z=%b n=%b expected z=0 n=0", rsp_zero, rsp_neg); end
    n_tests++; if (rsp_tag !== 4'd3) begin n_fail++; $display("FAIL single_tag: got %h expected 3", rsp_tag); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    n_tests++; if (op_count !== 4'd1) begin n_fail++; $display("FAIL single_op_count: got %0d expected 1", op_count); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_idle: got rsp_valid %b expected 00", rsp_valid); end
    $display("[TB] single op: q=%0d tag=%0d count=%0d", rsp_q, rsp_tag, op_count);
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_q;
    logic [3:0]  exp_tag;
    do_reset();
    req_a0 = 32'd10; req_b0 = 32'd1; req_op0 = ALU_ADD; req_tag0 = 4'd1;
    req_a1 = 32'd20; req_b1 = 32'd2; req_op1 = ALU_SUB; req_tag1 = 4'd2;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_q   = (i % 2 == 0) ? 32'd11 : 32'd18;
      exp_tag = (i % 2 == 0) ? 4'd1 : 4'd2;
      #1;
      n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL contention_grant%0d: got %b expected %b", i, req_ready, exp_rdy); end
      tick();
      n_tests++; if (rsp_valid !== exp_rdy || rsp_q !== exp_q || rsp_tag !== exp_tag) begin n_fail++; $display("FAIL contention_rsp%0d: got v=%b q=%h t=%h expected v=%b q=%h t=%h", i, rsp_valid, rsp_q, rsp_tag, exp_rdy, exp_q, exp_tag); end
      n_tests++; if (op_count !== 4'(i)) begin n_fail++; $display("FAIL contention_count%0d: got %0d expected %0d", i, op_count, i); end
      $display("[TB] contention cycle %0d: grant=%b q=%0d", i, exp_rdy, rsp_q);
    end
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b00;
    n_tests++; if (op_count !== 4'd4 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL contention_end: got count=%0d v=%b expected count=4 v=00", op_count, rsp_valid); end
  endtask

  task automatic test_backpressure();
    req_a1 = 32'd3; req_b1 = 32'd5; req_op1 = ALU_SUB; req_tag1 = 4'd9;
    req_valid = 2'b10; rsp_ready = 2'b00;
    #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b11; rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_req_ready%0d: got %b expected 00", i, req_ready); end
      n_tests++; if (rsp_valid !== 2'b10 || rsp_q !== 32'hFFFF_FFFE || rsp_neg !== 1'b1 || rsp_zero !== 1'b0 || rsp_tag !== 4'd9) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b q=%h z=%b n=%b t=%h expected v=10 q=fffffffe z=0 n=1 t=9", i, rsp_valid, rsp_q, rsp_zero, rsp_neg, rsp_tag); end
      tick();
    end
    n_tests++; if (op_count !== 4'd4) begin n_fail++; $display("FAIL bp_ignored_ready: got count %0d expected 4", op_count); end
    req_valid = 2'b00; rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    n_tests++; if (op_count !== 4'd5 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_release: got count=%0d v=%b expected count=5 v=00", op_count, rsp_valid); end
    $display("[TB] backpressure: held 5 cycles, count=%0d", op_count);
  endtask

  task automatic test_flags();
    req_a0 = 32'hA5A5_A5A5; req_b0 = 32'hA5A5_A5A5; req_op0 = ALU_XOR; req_tag0 = 4'd4;
    req_valid = 2'b01; rsp_ready = 2'b01;
    tick();
    n_tests++; if (rsp_q !== 32'd0 || rsp_zero !== 1'b1 || rsp_neg !== 1'b0) begin n_fail++; $display("FAIL flags_xor: got q=%h z=%b n=%b expected q=0 z=1 n=0", rsp_q, rsp_zero, rsp_neg); end
    $display("[TB] xor: q=%h z=%b", rsp_q, rsp_zero);
    req_a0 = 32'h8000_0000; req_b0 = 32'd31; req_op0 = ALU_SRA; req_tag0 = 4'd5;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL flags_b2b_ready: got %b expected 01", req_ready); end
    tick();
    n_tests++; if (rsp_valid !== 2'b01 || rsp_q !== 32'hFFFF_FFFF || rsp_neg !== 1'b1 || rsp_zero !== 1'b0 || rsp_tag !== 4'd5) begin n_fail++; $display("FAIL flags_sra: got v=%b q=%h z=%b n=%b t=%h expected v=01 q=ffffffff z=0 n=1 t=5", rsp_valid, rsp_q, rsp_zero, rsp_neg, rsp_tag); end
    $display("[TB] sra: q=%h n=%b", rsp_q, rsp_neg);
    req_a0 = 32'd123; req_b0 = 32'd4; req_op0 = alu_op_e'(4'hF); req_tag0 = 4'd6;
    tick();
    n_tests++; if (rsp_q !== 32'd0 || rsp_zero !== 1'b1 || rsp_neg !== 1'b0 || rsp_tag !== 4'd6) begin n_fail++; $display("FAIL flags_undecoded: got q=%h z=%b n=%b t=%h expected q=0 z=1 n=0 t=6", rsp_q, rsp_zero, rsp_neg, rsp_tag); end
    $display("[TB] undecoded op: q=%h z=%b", rsp_q, rsp_zero);
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b00;
    n_tests++; if (op_count !== 4'd8) begin n_fail++; $display("FAIL flags_count: got %0d expected 8", op_count); end
  endtask

  task automatic test_reset_mid_hold();
    req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = ALU_ADD; req_tag1 = 4'd7;
    req_valid = 2'b10; rsp_ready = 2'b00;
    tick();
    req_valid = 2'b11;
    n_tests++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL midrst_hold: got %b expected 10", rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 2'b00 || op_count !== 4'd0) begin n_fail++; $display("FAIL midrst_async: got v=%b count=%0d expected v=00 count=0", rsp_valid, op_count); end
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL midrst_req_ready: got %b expected 00", req_ready); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_first_grant: got %b expected 01", req_ready); end
    req_a0 = 32'd2; req_b0 = 32'd2; req_op0 = ALU_ADD; req_tag0 = 4'd8;
    tick();
    req_valid = 2'b00;
    n_tests++; if (rsp_valid !== 2'b01 || rsp_q !== 32'd4) begin n_fail++; $display("FAIL midrst_rsp: got v=%b q=%h expected v=01 q=4", rsp_valid, rsp_q); end
    $display("[TB] reset mid-hold: v=%b count=%0d", rsp_valid, op_count);
  endtask

  task automatic test_wrap();
    do_reset();
    req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = ALU_OR; req_tag0 = 4'd1;
    req_valid = 2'b01; rsp_ready = 2'b01;
    for (int i = 1; i <= 16; i++) tick();
    n_tests++; if (op_count !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d expected 15", op_count); end
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b00;
    n_tests++; if (op_count !== 4'd0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wrap_0: got count=%0d v=%b expected count=0 v=00", op_count, rsp_valid); end
    $display("[TB] wrap: count=%0d", op_count);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flags();
    test_reset_mid_hold();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
